// File: rtl/dctq_pkg.sv
// Shared constants and FSM state type for the DCT coefficient quantizer.
package dctq_pkg;

    localparam int unsigned DW_DEF    = 12;
    localparam int unsigned QW_DEF    = 8;
    localparam int unsigned BLK_LEN   = 64;
    localparam int unsigned IDX_W     = $clog2(BLK_LEN);
    localparam int unsigned ROM_LAT   = 1;
    localparam int unsigned RND_CONST = 128;
    localparam int unsigned Q_FRAC    = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/quant_mul.sv
// Signed coefficient times unsigned reciprocal, round-half-up, shift by 8, registered.
module quant_mul
    import dctq_pkg::*;
#(
    parameter int unsigned DW = DW_DEF,
    parameter int unsigned QW = QW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [DW-1:0] a,
    input  logic [QW-1:0] q,
    output logic [DW-1:0] y
);

    localparam int unsigned PW = DW + QW + 1;

    logic signed [PW-1:0] a_ext_c;
    logic signed [PW-1:0] q_ext_c;
    logic signed [PW-1:0] prod_c;
    logic [DW-1:0]        y_d;
    logic [DW-1:0]        y_q;

    // Full-precision product; q is zero-extended so it stays non-negative.
    always_comb begin
        a_ext_c = {{(QW + 1){a[DW-1]}}, a};
        q_ext_c = {{(DW + 1){1'b0}}, q};
        prod_c  = a_ext_c * q_ext_c;
    end

    // Round, arithmetic shift and truncate; |q| < 1 so no saturation is needed.
    always_comb begin
        y_d = y_q;
        if (en) begin
            y_d = DW'((prod_c + $signed(PW'(RND_CONST))) >>> Q_FRAC);
        end
    end

    // Output register holds its value between valid results.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_q <= '0;
        end else begin
            y_q <= y_d;
        end
    end

    assign y = y_q;

endmodule

// File: rtl/quant_seq.sv
// Block sequencer: walks 64 coefficients through the ROM lookup and quantizer.
module quant_seq
    import dctq_pkg::*;
#(
    parameter int unsigned DW = DW_DEF,
    parameter int unsigned QW = QW_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [DW-1:0]    din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic [IDX_W-1:0] rom_addr,
    input  logic [QW-1:0]    rom_data,
    output logic [DW-1:0]    dout,
    output logic             dout_valid,
    output logic [IDX_W-1:0] dout_idx,
    output logic             dout_last,
    output logic             busy,
    output logic             done
);

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(BLK_LEN - 1);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [DW-1:0]    din_q, din_d;
    logic             v1_q, v1_d;
    logic [IDX_W-1:0] vidx_q, vidx_d;
    logic             dout_valid_q, dout_valid_d;
    logic [IDX_W-1:0] dout_idx_q, dout_idx_d;
    logic             dout_last_q, dout_last_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;
    logic             din_ready_q, din_ready_d;
    logic             accept_c;
    logic             mul_en_c;

    // Next-state, counter and valid-pipeline logic; abort overrides everything.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        din_d        = din_q;
        v1_d         = 1'b0;
        vidx_d       = vidx_q;
        done_d       = 1'b0;
        accept_c     = din_valid && din_ready_q && !abort;
        mul_en_c     = v1_q && !abort;
        dout_valid_d = mul_en_c;
        dout_idx_d   = mul_en_c ? vidx_q : dout_idx_q;
        dout_last_d  = mul_en_c && (vidx_q == IDX_LAST);

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    idx_d   = '0;
                end
            end
            ST_RUN: begin
                if (accept_c) begin
                    din_d  = din;
                    v1_d   = 1'b1;
                    vidx_d = idx_q;
                    idx_d  = idx_q + IDX_W'(1);
                    if (idx_q == IDX_LAST) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (dout_valid_q && dout_last_q) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (abort) begin
            state_d = ST_IDLE;
            idx_d   = '0;
            v1_d    = 1'b0;
            done_d  = 1'b0;
        end

        busy_d      = (state_d == ST_RUN) || (state_d == ST_DRAIN);
        din_ready_d = (state_d == ST_RUN);
    end

    // State, counter and pipeline registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            din_q        <= '0;
            v1_q         <= 1'b0;
            vidx_q       <= '0;
            dout_valid_q <= 1'b0;
            dout_idx_q   <= '0;
            dout_last_q  <= 1'b0;
            done_q       <= 1'b0;
            busy_q       <= 1'b0;
            din_ready_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            din_q        <= din_d;
            v1_q         <= v1_d;
            vidx_q       <= vidx_d;
            dout_valid_q <= dout_valid_d;
            dout_idx_q   <= dout_idx_d;
            dout_last_q  <= dout_last_d;
            done_q       <= done_d;
            busy_q       <= busy_d;
            din_ready_q  <= din_ready_d;
        end
    end

    // Multiply/round stage, loaded one edge after acceptance when the ROM entry is ready.
    quant_mul #(
        .DW (DW),
        .QW (QW)
    ) u_mul (
        .clk (clk),
        .rst (rst),
        .en  (mul_en_c),
        .a   (din_q),
        .q   (rom_data),
        .y   (dout)
    );

    assign rom_addr   = idx_q;
    assign din_ready  = din_ready_q;
    assign dout_valid = dout_valid_q;
    assign dout_idx   = dout_idx_q;
    assign dout_last  = dout_last_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_quant_seq.sv
// Randomized bench for quant_seq with a scoreboard of expected outputs per cycle.
module tb_quant_seq;

    localparam int DW = 12;
    localparam int QW = 8;

    logic          clk;
    logic          rst;
    logic          start;
    logic          abort;
    logic [DW-1:0] din;
    logic          din_valid;
    logic          din_ready;
    logic [5:0]    rom_addr;
    logic [QW-1:0] rom_data;
    logic [DW-1:0] dout;
    logic          dout_valid;
    logic [5:0]    dout_idx;
    logic          dout_last;
    logic          busy;
    logic          done;

    quant_seq #(.DW(DW), .QW(QW)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .din        (din),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_idx   (dout_idx),
        .dout_last  (dout_last),
        .busy       (busy),
        .done       (done)
    );

    typedef struct {
        int     idx;
        int     val;
        longint due;
    } exp_t;

    exp_t       expq[$];
    exp_t       e;
    logic [7:0] rom [64];
    longint     cyc;
    longint     done_due;
    int         last_dout;
    int         last_idx;
    int         n_cmp;
    int         n_bad;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered ROM model: one edge of latency.
    always @(posedge clk) rom_data <= rom[rom_addr];

    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string tag, input longint got, input longint exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Quantizer reference: floor((d*q + 128) / 256).
    function automatic int ref_q(input int d, input int q);
        int t;
        t = d * q + 128;
        if (t >= 0) return t / 256;
        return -((-t + 255) / 256);
    endfunction

    // Per-cycle scoreboard: an output exactly when one is due, otherwise quiet and held.
    always @(negedge clk) begin
        if (!rst) begin
            if (expq.size() > 0 && expq[0].due == cyc) begin
                e = expq.pop_front();
                chk("dv", dout_valid, 1);
                chk("dout", $signed(dout), e.val);
                chk("idx", dout_idx, e.idx);
                chk("last", dout_last, (e.idx == 63) ? 1 : 0);
                last_dout = e.val;
                last_idx  = e.idx;
                if (e.idx == 63) done_due = cyc + 1;
            end else begin
                chk("bubble", dout_valid, 0);
                chk("hold_dout", $signed(dout), last_dout);
                chk("hold_idx", dout_idx, last_idx);
            end
            chk("done", done, (cyc == done_due) ? 1 : 0);
        end
    end

    task automatic flush();
        expq.delete();
        done_due = -1;
    endtask

    task automatic check_reset_vals();
        chk("rst_dout", dout, 0);
        chk("rst_didx", dout_idx, 0);
        chk("rst_dv", dout_valid, 0);
        chk("rst_last", dout_last, 0);
        chk("rst_done", done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rdy", din_ready, 0);
        chk("rst_addr", rom_addr, 0);
    endtask

    task automatic set_rom(input int q0, input int q63);
        for (int k = 0; k < 64; k++) rom[k] = 8'($urandom_range(0, 255));
        if (q0 >= 0) rom[0] = 8'(q0);
        if (q63 >= 0) rom[63] = 8'(q63);
    endtask

    // mode 0: back-to-back, 1: alternate gaps, 2: random gaps plus stray start.
    // cut_at >= 0 cancels the block at that index by abort or (cut_rst) reset.
    task automatic run_block(input int mode, input int cut_at, input bit cut_rst,
                             input int d0, input int d63);
        int     gap;
        int     dv;
        int     t;
        longint first_acc;
        longint last_acc;
        first_acc = 0;
        last_acc  = 0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_start", busy, 1);
        chk("rdy_start", din_ready, 1);
        for (int k = 0; k < 64; k++) begin
            gap = (mode == 1) ? ((k > 0) ? 1 : 0) : (mode == 2) ? $urandom_range(0, 3) : 0;
            repeat (gap) begin
                din_valid = 1'b0;
                din = DW'($urandom);
                @(posedge clk); #1;
            end
            dv  = (k == 0) ? d0 : (k == 63) ? d63 : $urandom_range(0, 4095) - 2048;
            din = DW'(dv);
            din_valid = 1'b1;
            if (mode == 2 && k == 20) start = 1'b1;
            if (k == cut_at && !cut_rst) abort = 1'b1;
            @(negedge clk);
            chk("rdy", din_ready, 1);
            chk("addr", rom_addr, k);
            if (k == cut_at && cut_rst) begin
                rst = 1'b1;
                #1;
                check_reset_vals();
                flush();
                last_dout = 0;
                last_idx  = 0;
                din_valid = 1'b0;
                repeat (2) @(posedge clk);
                @(negedge clk);
                rst = 1'b0;
                repeat (6) @(negedge clk);
                chk("busy_after_rst", busy, 0);
                return;
            end
            if (k == cut_at) begin
                @(posedge clk); #1;
                abort = 1'b0;
                din_valid = 1'b0;
                flush();
                chk("busy_abort", busy, 0);
                chk("addr_abort", rom_addr, 0);
                repeat (6) @(negedge clk);
                chk("busy_after_abort", busy, 0);
                return;
            end
            expq.push_back('{idx: k, val: ref_q(dv, int'(rom[k])), due: cyc + 2});
            if (k == 0) first_acc = cyc;
            last_acc = cyc;
            @(posedge clk); #1;
            start = 1'b0;
        end
        din_valid = 1'b0;
        if (mode == 1) chk("span", last_acc - first_acc, 126);
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!done && t < 10);
        chk("done_seen", done, 1);
        // Start during DONE must be ignored.
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chk("busy_idle", busy, 0);
        chk("rdy_idle", din_ready, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp = 0;
        n_bad = 0;
        cyc = 0;
        done_due = -1;
        last_dout = 0;
        last_idx = 0;
        rst = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        din = '0;
        din_valid = 1'b0;
        set_rom(-1, -1);
        #1 rst = 1'b1;
        #1 check_reset_vals();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // din_valid in IDLE is ignored.
        din_valid = 1'b1;
        din = DW'(123);
        repeat (4) begin
            @(negedge clk);
            chk("rdy_in_idle", din_ready, 0);
        end
        din_valid = 1'b0;
        @(posedge clk); #1;

        set_rom(8'hFF, -1);
        run_block(0, -1, 1'b0, 100, $urandom_range(0, 4095) - 2048);

        set_rom(8'hFF, 8'h19);
        run_block(0, -1, 1'b0, -100, 2047);

        set_rom(-1, -1);
        run_block(1, -1, 1'b0, $urandom_range(0, 4095) - 2048, -2048);

        set_rom(-1, 8'hFF);
        run_block(2, -1, 1'b0, 2047, -2048);

        set_rom(-1, -1);
        run_block(0, 30, 1'b0, 5, 5);
        run_block(0, -1, 1'b0, -1, 1);

        set_rom(-1, -1);
        run_block(0, 40, 1'b1, 7, 7);
        run_block(2, -1, 1'b0, -2048, 2047);

        repeat (4) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
